// File: rtl/riscv_exec_pkg.sv
// Shared encodings for the RV32 execute stage: ALUOp classes, ALU control codes and funct3 values.
package riscv_exec_pkg;

    localparam logic [2:0] ALUOP_MEM    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
    localparam logic [2:0] ALUOP_ITYPE  = 3'b011;
    localparam logic [2:0] ALUOP_LUI    = 3'b100;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/riscv_alu_decode.sv
// Combinational ALUOp/funct -> 4-bit ALU control decoder for the RV32 execute stage.
module riscv_alu_decode
    import riscv_exec_pkg::*;
(
    input  logic [2:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_ctrl_o
);

    logic [3:0] arith_ctrl;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        arith_ctrl = ALU_ADD;
        case (funct3_i)
            // ADDI has no SUB form; instruction[30] is part of the immediate there.
            F3_ADD_SUB: arith_ctrl = (funct7_5_i && alu_op_i == ALUOP_RTYPE) ? ALU_SUB : ALU_ADD;
            F3_SLL:     arith_ctrl = ALU_SLL;
            F3_SLT:     arith_ctrl = ALU_SLT;
            F3_SLTU:    arith_ctrl = ALU_SLTU;
            F3_XOR:     arith_ctrl = ALU_XOR;
            F3_SRL_SRA: arith_ctrl = funct7_5_i ? ALU_SRA : ALU_SRL;
            F3_OR:      arith_ctrl = ALU_OR;
            F3_AND:     arith_ctrl = ALU_AND;
            default:    arith_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_MEM:    alu_ctrl_o = ALU_ADD;
            ALUOP_BRANCH: alu_ctrl_o = ALU_SUB;
            ALUOP_RTYPE,
            ALUOP_ITYPE:  alu_ctrl_o = arith_ctrl;
            ALUOP_LUI:    alu_ctrl_o = ALU_PASSB;
            default:      alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_exec_unit.sv
// Registered RV32 execute stage: ALU with zero flag plus PC+4 and PC+imm adders, one cycle latency.
// Optional NZCV-style flag outputs are enabled by defining RISCV_EXEC_FLAGS_EN.
module riscv_exec_unit
    import riscv_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] pc_plus4,
`ifdef RISCV_EXEC_FLAGS_EN
    output logic            negative,
    output logic            carry,
    output logic            overflow,
`endif
    output logic [XLEN-1:0] branch_target
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [3:0]         alu_ctrl_d;
    logic [XLEN-1:0]    result_d;
    logic               zero_d;
    logic [XLEN-1:0]    pc_plus4_d;
    logic [XLEN-1:0]    branch_target_d;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    add_sum;
    logic [XLEN-1:0]    sub_diff;

    logic               valid_q;
    logic [3:0]         alu_ctrl_q;
    logic [XLEN-1:0]    result_q;
    logic               zero_q;
    logic [XLEN-1:0]    pc_plus4_q;
    logic [XLEN-1:0]    branch_target_q;

    riscv_alu_decode u_decode (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .alu_ctrl_o (alu_ctrl_d)
    );

    assign shamt = operand_b[SHAMT_W-1:0];

`ifdef RISCV_EXEC_FLAGS_EN
    logic [XLEN:0] add_ext;
    logic [XLEN:0] sub_ext;
    logic          negative_d, carry_d, overflow_d;
    logic          negative_q, carry_q, overflow_q;

    // Subtraction as a + ~b + 1 so the carry-out is the inverted borrow.
    assign add_ext  = {1'b0, operand_a} + {1'b0, operand_b};
    assign sub_ext  = {1'b0, operand_a} + {1'b0, ~operand_b} + (XLEN+1)'(1);
    assign add_sum  = add_ext[XLEN-1:0];
    assign sub_diff = sub_ext[XLEN-1:0];

    always_comb begin
        negative_d = result_d[XLEN-1];
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        if (alu_ctrl_d == ALU_ADD) begin
            carry_d    = add_ext[XLEN];
            overflow_d = (operand_a[XLEN-1] == operand_b[XLEN-1]) &&
                         (add_sum[XLEN-1] != operand_a[XLEN-1]);
        end else if (alu_ctrl_d == ALU_SUB) begin
            carry_d    = sub_ext[XLEN];
            overflow_d = (operand_a[XLEN-1] != operand_b[XLEN-1]) &&
                         (sub_diff[XLEN-1] != operand_a[XLEN-1]);
        end
    end
`else
    assign add_sum  = operand_a + operand_b;
    assign sub_diff = operand_a - operand_b;
`endif

    always_comb begin
        result_d = '0;
        case (alu_ctrl_d)
            ALU_AND:   result_d = operand_a & operand_b;
            ALU_OR:    result_d = operand_a | operand_b;
            ALU_ADD:   result_d = add_sum;
            ALU_XOR:   result_d = operand_a ^ operand_b;
            ALU_SLL:   result_d = operand_a << shamt;
            ALU_SRL:   result_d = operand_a >> shamt;
            ALU_SUB:   result_d = sub_diff;
            ALU_SRA:   result_d = $unsigned($signed(operand_a) >>> shamt);
            ALU_SLT:   result_d = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU:  result_d = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            ALU_PASSB: result_d = operand_b;
            default:   result_d = '0;
        endcase
    end

    assign zero_d          = (result_d == '0);
    assign pc_plus4_d      = pc + XLEN'(4);
    assign branch_target_d = pc + imm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q         <= 1'b0;
            alu_ctrl_q      <= '0;
            result_q        <= '0;
            zero_q          <= 1'b0;
            pc_plus4_q      <= '0;
            branch_target_q <= '0;
`ifdef RISCV_EXEC_FLAGS_EN
            negative_q      <= 1'b0;
            carry_q         <= 1'b0;
            overflow_q      <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            valid_q <= in_valid;
            if (in_valid) begin
                alu_ctrl_q      <= alu_ctrl_d;
                result_q        <= result_d;
                zero_q          <= zero_d;
                pc_plus4_q      <= pc_plus4_d;
                branch_target_q <= branch_target_d;
`ifdef RISCV_EXEC_FLAGS_EN
                negative_q      <= negative_d;
                carry_q         <= carry_d;
                overflow_q      <= overflow_d;
`endif
            end
        end
    end

    assign out_valid     = valid_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign result        = result_q;
    assign zero          = zero_q;
    assign pc_plus4      = pc_plus4_q;
    assign branch_target = branch_target_q;
`ifdef RISCV_EXEC_FLAGS_EN
    assign negative      = negative_q;
    assign carry         = carry_q;
    assign overflow      = overflow_q;
`endif

endmodule

// File: tb/tb_riscv_exec_unit.sv
// Self-checking bench for riscv_exec_unit: directed cases plus randomized streams against a behavioural model.
// Flag outputs are checked when RISCV_EXEC_FLAGS_EN is defined.
module tb_riscv_exec_unit;
    import riscv_exec_pkg::*;

    localparam int XLEN = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [2:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] operand_a, operand_b, pc, imm;
    logic            out_valid;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] pc_plus4, branch_target;
`ifdef RISCV_EXEC_FLAGS_EN
    logic            negative, carry, overflow;
`endif

    always #5 clk = ~clk;

    riscv_exec_unit #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .alu_op        (alu_op),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .pc            (pc),
        .imm           (imm),
        .out_valid     (out_valid),
        .alu_ctrl      (alu_ctrl),
        .result        (result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
`ifdef RISCV_EXEC_FLAGS_EN
        .negative      (negative),
        .carry         (carry),
        .overflow      (overflow),
`endif
        .branch_target (branch_target)
    );

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic [31:0] pc4;
        logic [31:0] bt;
`ifdef RISCV_EXEC_FLAGS_EN
        logic        neg;
        logic        carry;
        logic        ovf;
`endif
    } out_t;

    int   total = 0;
    int   bad   = 0;
    out_t last;

    function automatic out_t observed();
        out_t o;
        o.valid = out_valid;
        o.ctrl  = alu_ctrl;
        o.res   = result;
        o.zero  = zero;
        o.pc4   = pc_plus4;
        o.bt    = branch_target;
`ifdef RISCV_EXEC_FLAGS_EN
        o.neg   = negative;
        o.carry = carry;
        o.ovf   = overflow;
`endif
        return o;
    endfunction

    // Reference: what the instruction means, computed with plain arithmetic.
    function automatic out_t model(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] p, input logic [31:0] im);
        out_t        o;
        logic [3:0]  tbl [8];
        logic [3:0]  c;
        logic [31:0] r;
        int          s;
        longint      sa, sb, sr;
        longint unsigned ua, ub;
        o   = '0;
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        s   = int'(b[4:0]);
        if (op == 3'd1)                   c = ALU_SUB;
        else if (op == 3'd4)              c = ALU_PASSB;
        else if (op == 3'd2 || op == 3'd3) begin
            c = tbl[f3];
            if (f3 == 3'd5 && f7)             c = ALU_SRA;
            if (f3 == 3'd0 && f7 && op == 3'd2) c = ALU_SUB;
        end else                          c = ALU_ADD;
        case (c)
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_ADD:   r = a + b;
            ALU_XOR:   r = a ^ b;
            ALU_SLL:   r = a << s;
            ALU_SRL:   r = a >> s;
            ALU_SUB:   r = a - b;
            ALU_SRA:   r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            ALU_SLT:   r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            ALU_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            ALU_PASSB: r = b;
            default:   r = 32'd0;
        endcase
        o.valid = 1'b1;
        o.ctrl  = c;
        o.res   = r;
        o.zero  = (r == 32'd0);
        o.pc4   = p + 32'd4;
        o.bt    = p + im;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
`ifdef RISCV_EXEC_FLAGS_EN
        o.neg = r[31];
        if (c == ALU_ADD) begin
            sr      = sa + sb;
            o.carry = (ua + ub) > 64'hFFFF_FFFF;
            o.ovf   = (sr > SMAX) || (sr < SMIN);
        end else if (c == ALU_SUB) begin
            sr      = sa - sb;
            o.carry = (a >= b);
            o.ovf   = (sr > SMAX) || (sr < SMIN);
        end
`else
        sr = sa + sb + longint'(ua) + longint'(ub);
        if (sr == SMIN) o.res = r;
`endif
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] im);
        in_valid  = v;
        alu_op    = op;
        funct3    = f3;
        funct7_5  = f7;
        operand_a = a;
        operand_b = b;
        pc        = p;
        imm       = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show_fail(input string name, input logic [127:0] got, input logic [127:0] exp);
        $display("FAIL %s: got=%h expected=%h", name, got, exp);
    endtask

    task automatic test_reset();
        tick();
        total++;
        if (observed() !== out_t'('0)) begin bad++; show_fail("reset_initial", observed(), '0); end
        reset = 1'b1;
        drive(1'b1, 3'b000, 3'b000, 1'b0, 32'd1, 32'd2, 32'h10, 32'h4);
        tick();
        total++;
        if ({out_valid, result, pc_plus4, branch_target} !== {1'b1, 32'd3, 32'h14, 32'h14}) begin
            bad++; show_fail("first_after_reset", {out_valid, result, pc_plus4, branch_target},
                             {1'b1, 32'd3, 32'h14, 32'h14});
        end
        drive(1'b1, 3'b000, 3'b000, 1'b0, 32'd9, 32'd9, 32'h20, 32'h8);
        #3 reset = 1'b0;
        #1;
        total++;
        if (observed() !== out_t'('0)) begin bad++; show_fail("reset_async", observed(), '0); end
        tick();
        total++;
        if (observed() !== out_t'('0)) begin bad++; show_fail("reset_held", observed(), '0); end
        reset = 1'b1;
        drive(1'b1, 3'b010, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0, 32'h40, 32'h40);
        tick();
        total++;
        if ({out_valid, alu_ctrl, result} !== {1'b1, 4'b0000, 32'h00F0}) begin
            bad++; show_fail("release_valid", {out_valid, alu_ctrl, result}, {1'b1, 4'b0000, 32'h00F0});
        end
    endtask

    task automatic test_rtype();
        drive(1'b1, 3'b010, 3'b000, 1'b1, 32'd7, 32'd7, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result, zero} !== {4'b0110, 32'd0, 1'b1}) begin
            bad++; show_fail("rtype_sub", {alu_ctrl, result, zero}, {4'b0110, 32'd0, 1'b1});
        end
        drive(1'b1, 3'b010, 3'b000, 1'b0, 32'd7, 32'd7, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result, zero} !== {4'b0010, 32'd14, 1'b0}) begin
            bad++; show_fail("rtype_add", {alu_ctrl, result, zero}, {4'b0010, 32'd14, 1'b0});
        end
    endtask

    task automatic test_shift_cmp();
        drive(1'b1, 3'b010, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result} !== {4'b0111, 32'hF800_0000}) begin
            bad++; show_fail("sra", {alu_ctrl, result}, {4'b0111, 32'hF800_0000});
        end
        drive(1'b1, 3'b010, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result} !== {4'b0101, 32'h0800_0000}) begin
            bad++; show_fail("srl", {alu_ctrl, result}, {4'b0101, 32'h0800_0000});
        end
        drive(1'b1, 3'b010, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result, zero} !== {4'b1000, 32'd1, 1'b0}) begin
            bad++; show_fail("slt", {alu_ctrl, result, zero}, {4'b1000, 32'd1, 1'b0});
        end
        drive(1'b1, 3'b010, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result, zero} !== {4'b1001, 32'd0, 1'b1}) begin
            bad++; show_fail("sltu", {alu_ctrl, result, zero}, {4'b1001, 32'd0, 1'b1});
        end
    endtask

    task automatic test_itype_lui();
        drive(1'b1, 3'b011, 3'b000, 1'b1, 32'd5, 32'd3, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result} !== {4'b0010, 32'd8}) begin
            bad++; show_fail("addi", {alu_ctrl, result}, {4'b0010, 32'd8});
        end
        drive(1'b1, 3'b100, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h1234_5000, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result} !== {4'b1010, 32'h1234_5000}) begin
            bad++; show_fail("lui", {alu_ctrl, result}, {4'b1010, 32'h1234_5000});
        end
        drive(1'b1, 3'b001, 3'b111, 1'b0, 32'd3, 32'd5, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result} !== {4'b0110, 32'hFFFF_FFFE}) begin
            bad++; show_fail("branch_sub", {alu_ctrl, result}, {4'b0110, 32'hFFFF_FFFE});
        end
        drive(1'b1, 3'b110, 3'b101, 1'b1, 32'd10, 32'd20, 32'h0, 32'h0);
        tick();
        total++;
        if ({alu_ctrl, result} !== {4'b0010, 32'd30}) begin
            bad++; show_fail("aluop_reserved", {alu_ctrl, result}, {4'b0010, 32'd30});
        end
    endtask

    task automatic test_adders();
        drive(1'b1, 3'b000, 3'b000, 1'b0, 32'd0, 32'd0, 32'h100, 32'hFFFF_FFF8);
        tick();
        total++;
        if ({pc_plus4, branch_target} !== {32'h104, 32'hF8}) begin
            bad++; show_fail("adders", {pc_plus4, branch_target}, {32'h104, 32'hF8});
        end
        drive(1'b1, 3'b000, 3'b000, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h4);
        tick();
        total++;
        if ({pc_plus4, branch_target} !== {32'h0, 32'h0}) begin
            bad++; show_fail("adders_wrap", {pc_plus4, branch_target}, {32'h0, 32'h0});
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 3'b000, 3'b000, 1'b0, 32'd3, 32'd4, 32'h200, 32'h20);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 3'b010, 3'b000, 1'b1, $urandom, $urandom, $urandom, $urandom);
            tick();
            total++;
            if ({out_valid, alu_ctrl, result, zero, pc_plus4, branch_target} !==
                {1'b0, 4'b0010, 32'd7, 1'b0, 32'h204, 32'h220}) begin
                bad++;
                show_fail("hold", {out_valid, alu_ctrl, result, zero, pc_plus4, branch_target},
                          {1'b0, 4'b0010, 32'd7, 1'b0, 32'h204, 32'h220});
            end
        end
    endtask

`ifdef RISCV_EXEC_FLAGS_EN
    task automatic test_flags();
        logic [31:0] av [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3};
        logic [31:0] bv [4] = '{32'd1,         32'd1,         32'd3, 32'd5};
        logic [2:0]  ov [4] = '{3'b000,        3'b000,        3'b001, 3'b001};
        logic [2:0]  ev [4] = '{3'b101,        3'b010,        3'b010, 3'b100};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ov[i], 3'b000, 1'b0, av[i], bv[i], 32'h0, 32'h0);
            tick();
            total++;
            if ({negative, carry, overflow} !== ev[i]) begin
                bad++; show_fail($sformatf("flags_%0d", i), {negative, carry, overflow}, ev[i]);
            end
        end
    endtask
`endif

    task automatic test_stream(input string name, input int n, input bit all_valid);
        logic        v;
        logic [2:0]  op, f3;
        logic        f7;
        logic [31:0] a, b, p, im;
        out_t        exp;
        for (int i = 0; i < n; i++) begin
            v  = (all_valid || i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            a  = rand_word();
            b  = rand_word();
            p  = rand_word();
            im = rand_word();
            drive(v, op, f3, f7, a, b, p, im);
            tick();
            if (v) last = model(op, f3, f7, a, b, p, im);
            exp       = last;
            exp.valid = v;
            total++;
            if (observed() !== exp) begin
                bad++; show_fail($sformatf("%s_%0d", name, i), observed(), exp);
            end
        end
        drive(1'b0, 3'b000, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        last  = '0;
        drive(1'b0, 3'b000, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_rtype();
        test_shift_cmp();
        test_itype_lui();
        test_adders();
        test_hold();
`ifdef RISCV_EXEC_FLAGS_EN
        test_flags();
`endif
        test_stream("random", 300, 1'b0);
        test_stream("back_to_back", 40, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
